// File: rtl/shift_seq.sv
// shift_seq: sequential one-bit-per-clock shifter with start/busy/done handshake
module shift_seq #(
    parameter int size = 8,
    parameter int CNTW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [size-1:0] dataIn,
    input  logic [1:0]      codeShift,
    input  logic [CNTW-1:0] amount,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] shiftOut,
    output logic            carryOut,
    output logic            zeroOut
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      code;
    logic [CNTW-1:0] count;
    logic [size-1:0] step_res;
    logic            step_carry;
    logic            accept;

    assign accept  = start && (state == IDLE || state == DONE);
    assign busy    = state == SHIFT;
    assign done    = state == DONE;
    assign zeroOut = shiftOut == '0;

    // one shift step of the result: left for 10, right otherwise with sign fill only for 11
    always_comb begin
        step_res   = (code == 2'b10) ? {shiftOut[size-2:0], 1'b0}
                                     : {(code == 2'b11) & shiftOut[size-1], shiftOut[size-1:1]};
        step_carry = (code == 2'b10) ? shiftOut[size-1] : shiftOut[0];
    end

    // handshake state, operand capture and per-cycle shifting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            code     <= 2'b00;
            count    <= '0;
            shiftOut <= '0;
            carryOut <= 1'b0;
        end else if (accept) begin
            code     <= codeShift;
            count    <= amount;
            shiftOut <= dataIn;
            carryOut <= 1'b0;
            state    <= (amount == '0 || codeShift == 2'b00) ? DONE : SHIFT;
        end else if (state == SHIFT) begin
            shiftOut <= step_res;
            carryOut <= step_carry;
            count    <= count - 1'b1;
            state    <= (count == CNTW'(1)) ? DONE : SHIFT;
        end else begin
            state    <= IDLE;
        end
    end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: randomized scoreboard bench for shift_seq against an arithmetic reference model
module tb_shift_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dataIn = '0;
    logic [1:0] codeShift = '0;
    logic [2:0] amount = '0;
    logic       busy, done, carryOut, zeroOut;
    logic [7:0] shiftOut;

    int passed = 0;
    int total = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] r;
        logic       c;
        int         at;
    } exp_t;
    exp_t q[$];

    shift_seq #(.size(8), .CNTW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .dataIn(dataIn),
        .codeShift(codeShift), .amount(amount), .busy(busy), .done(done),
        .shiftOut(shiftOut), .carryOut(carryOut), .zeroOut(zeroOut)
    );

    always #5 clk = ~clk;

    // cycle counter used to check done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // result and carry after shifting d by n places, {carry, result}
    function automatic logic [8:0] model(input logic [7:0] d, input logic [1:0] c, input int n);
        int k;
        logic [7:0] r;
        logic cy;
        k = (c == 2'b00) ? 0 : n;
        r = d;
        cy = 1'b0;
        if (c == 2'b01) begin
            r = d >> k;
            cy = (k > 0) ? d[k-1] : 1'b0;
        end else if (c == 2'b10) begin
            r = d << k;
            cy = (k > 0) ? d[8-k] : 1'b0;
        end else if (c == 2'b11) begin
            r = $signed(d) >>> k;
            cy = (k > 0) ? d[k-1] : 1'b0;
        end
        return {cy, r};
    endfunction

    // monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("shiftOut", 32'(shiftOut), 32'(e.r));
                chk("carryOut", 32'(carryOut), 32'(e.c));
                chk("zeroOut", 32'(zeroOut), 32'(e.r == 8'h00));
                chk("done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // issue one operation at a negedge and wait for its done pulse
    task automatic run(input logic [7:0] d, input logic [1:0] c, input logic [2:0] n,
                       input bit b2b, input bit poke);
        int ne, bc;
        bit got;
        logic [8:0] m;
        ne = (c == 2'b00) ? 0 : int'(n);
        m = model(d, c, int'(n));
        start = 1'b1;
        dataIn = d;
        codeShift = c;
        amount = n;
        q.push_back('{r: m[7:0], c: m[8], at: cyc + 1 + ne});
        @(posedge clk);
        #1;
        start = 1'b0;
        dataIn = 8'($urandom);
        codeShift = 2'($urandom);
        amount = 3'($urandom);
        got = 0;
        bc = 0;
        for (int i = 0; i < 14 && !got; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) got = 1;
            else if (poke && busy) start = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(bc), 32'(ne));
        if (!b2b) @(negedge clk);
    endtask

    initial begin
        #2;
        chk("rst_zero", 32'(zeroOut), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_out", 32'(shiftOut), 32'd0);
        chk("idle_zero", 32'(zeroOut), 32'd1);
        chk("idle_carry", 32'(carryOut), 32'd0);

        run(8'hB4, 2'b01, 3'd3, 0, 0);
        run(8'h81, 2'b10, 3'd1, 0, 0);
        run(8'h90, 2'b11, 3'd4, 0, 0);
        run(8'h80, 2'b01, 3'd7, 0, 0);
        run(8'h5A, 2'b01, 3'd0, 0, 0);
        run(8'h5A, 2'b00, 3'd5, 0, 0);
        run(8'hC3, 2'b10, 3'd5, 1, 1);
        run(8'h0F, 2'b11, 3'd2, 1, 0);
        run(8'hF0, 2'b11, 3'd7, 0, 1);

        for (int i = 0; i < 40; i++)
            run(8'($urandom), 2'($urandom), 3'($urandom), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)));

        start = 1'b1;
        dataIn = 8'hA5;
        codeShift = 2'b01;
        amount = 3'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_out", 32'(shiftOut), 32'd0);
        chk("abort_carry", 32'(carryOut), 32'd0);
        chk("abort_zero", 32'(zeroOut), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        run(8'h3C, 2'b10, 3'd2, 0, 0);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
